interrupt_arbiter: RTL and testbench

- Upstream feeder of the exception handler. Samples platform interrupt lines and maintains the architectural mip pending bits.
- Masks pending interrupts with mie, mideleg, the mstatus global enables and the current privilege level, then selects the highest-priority interrupt.
- Presents the selected cause to the exception handler over a valid/ready handshake. After each accepted trap it holds off new requests for a fixed number of cycles so the handler can commit the mstatus update.

---
 rtl/interrupt_arbiter_pkg.sv | 77 +++++++
 rtl/interrupt_arbiter_irq_synchronizer.sv | 38 +++
 rtl/interrupt_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_interrupt_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_arbiter_pkg
// Description : Privileged-architecture types and constants shared by the
//               interrupt arbiter. These are the mip bit indices, the
//               software-writable mip mask, the arbiter state encoding and a
//               fixed-priority pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_arbiter_pkg;

    localparam int unsigned c_MXLEN = 64;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } privilege_level_t;

    typedef enum logic [3:0] {
        IRQ_S_SOFT  = 4'd1,
        IRQ_M_SOFT  = 4'd3,
        IRQ_S_TIMER = 4'd5,
        IRQ_M_TIMER = 4'd7,
        IRQ_S_EXT   = 4'd9,
        IRQ_M_EXT   = 4'd11,
        IRQ_LCOF    = 4'd13
    } asynchronous_exception_code_t;

    typedef struct packed {
        logic                 interrupt;
        logic [c_MXLEN-2:0]   code;
    } mcause_t;

    typedef logic [c_MXLEN-1:0] mip_t;

    // Interrupt bit positions inside mip / mie / mideleg
    localparam int unsigned c_IRQ_SSI   = 1;
    localparam int unsigned c_IRQ_MSI   = 3;
    localparam int unsigned c_IRQ_STI   = 5;
    localparam int unsigned c_IRQ_MTI   = 7;
    localparam int unsigned c_IRQ_SEI   = 9;
    localparam int unsigned c_IRQ_MEI   = 11;
    localparam int unsigned c_IRQ_LCOFI = 13;

    // Number of low mip bits that carry any implemented interrupt
    localparam int unsigned c_IRQ_W = 14;

    // Bits a CSR write can influence: SSIP, STIP, software SEIP, LCOFIP clear
    localparam mip_t c_MIP_SW_WRITABLE_MASK = mip_t'(64'h0000_0000_0000_2222);

    // M-level interrupts can never be delegated; these mideleg bits read as 0
    localparam logic [c_IRQ_W-1:0] c_MIDELEG_FORCED_ZERO = 14'h0888;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REQ     = 2'd1,
        ARB_HOLDOFF = 2'd2
    } arb_state_t;

    // Input is the eligible vector already ordered from highest priority
    // (bit 6: MEI) to lowest (bit 0: LCOFI).
    function automatic asynchronous_exception_code_t pick_irq(input logic [6:0] ord);
        asynchronous_exception_code_t code;
        code = IRQ_LCOF;
        if (ord[6])      code = IRQ_M_EXT;
        else if (ord[5]) code = IRQ_M_SOFT;
        else if (ord[4]) code = IRQ_M_TIMER;
        else if (ord[3]) code = IRQ_S_EXT;
        else if (ord[2]) code = IRQ_S_SOFT;
        else if (ord[1]) code = IRQ_S_TIMER;
        else if (ord[0]) code = IRQ_LCOF;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_arbiter_irq_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : irq_synchronizer
// Description : Single-bit flop-chain synchronizer of configurable depth,
//               asynchronously reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    generate
        if (STAGES == 1) begin : g_single
            // One-flop capture of the asynchronous line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= '0;
                else        r_sync <= i_d;
            end
        end else begin : g_chain
            // Shift the line through the metastability chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= '0;
                else        r_sync <= {r_sync[STAGES-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_arbiter
// Description : Maintains mip, masks pending interrupts by mie / mideleg /
//               global enables / privilege, picks the highest-priority one
//               and offers it to the exception handler over valid/ready,
//               followed by a fixed hold-off after every accepted trap.
//               Optional macro INTERRUPT_ARBITER_SYNC_EN inserts a
//               SYNC_STAGES-deep synchronizer on each platform line.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int unsigned MXLEN          = c_MXLEN,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             irq_meip_i,
    input  logic             irq_mtip_i,
    input  logic             irq_msip_i,
    input  logic             irq_seip_i,
    input  logic             irq_lcofip_i,
    input  logic             mip_we_i,
    input  logic [MXLEN-1:0] mip_wdata_i,
    input  logic [MXLEN-1:0] mie_i,
    input  logic [MXLEN-1:0] mideleg_i,
    input  logic             mstatus_mie_i,
    input  logic             mstatus_sie_i,
    input  logic [1:0]       priv_lvl_i,
    output logic             irq_valid_o,
    input  logic             irq_ready_i,
    output logic [MXLEN-1:0] irq_cause_o,
    output logic [1:0]       irq_target_priv_o,
    output logic [MXLEN-1:0] mip_o
);

    // Platform lines packed as {seip, msip, mtip, meip}
    logic [3:0] w_line_raw;
    logic [3:0] w_line;
    assign w_line_raw = {irq_seip_i, irq_msip_i, irq_mtip_i, irq_meip_i};

`ifdef INTERRUPT_ARBITER_SYNC_EN
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk_i),
                .rst_n (rstn_i),
                .i_d   (w_line_raw[gi]),
                .o_q   (w_line[gi])
            );
        end
    endgenerate
`else
    localparam int unsigned c_unused_sync_stages = SYNC_STAGES;
    assign w_line = w_line_raw;
`endif

    logic [3:0]         r_line;
    logic               r_ssip;
    logic               r_stip;
    logic               r_sw_seip;
    logic               r_lcofip;
    logic [MXLEN-1:0]   w_wdata_sw;
    logic [c_IRQ_W-1:0] w_mip;

    assign w_wdata_sw = mip_wdata_i & c_MIP_SW_WRITABLE_MASK;

    // mip storage: line mirrors plus the software-writable bits; an LCOF
    // pulse beats a simultaneous clearing write
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_line    <= '0;
            r_ssip    <= 1'b0;
            r_stip    <= 1'b0;
            r_sw_seip <= 1'b0;
            r_lcofip  <= 1'b0;
        end else begin
            r_line <= w_line;
            if (mip_we_i) begin
                r_ssip    <= w_wdata_sw[c_IRQ_SSI];
                r_stip    <= w_wdata_sw[c_IRQ_STI];
                r_sw_seip <= w_wdata_sw[c_IRQ_SEI];
            end
            if (irq_lcofip_i)
                r_lcofip <= 1'b1;
            else if (mip_we_i && !w_wdata_sw[c_IRQ_LCOFI])
                r_lcofip <= 1'b0;
        end
    end

    // Bit 13 LCOF, 11 MEI, 9 SEI, 7 MTI, 5 STI, 3 MSI, 1 SSI; the rest read 0
    assign w_mip = {r_lcofip, 1'b0, r_line[0], 1'b0, r_sw_seip | r_line[3], 1'b0,
                    r_line[1], 1'b0, r_stip, 1'b0, r_line[2], 1'b0, r_ssip, 1'b0};
    assign mip_o = MXLEN'(w_mip);

    logic               w_m_on;
    logic               w_s_on;
    logic [c_IRQ_W-1:0] w_deleg;
    logic [c_IRQ_W-1:0] w_pend_en;
    logic [c_IRQ_W-1:0] w_m_elig;
    logic [c_IRQ_W-1:0] w_s_elig;
    logic [15:0]        w_elig_any;

    // M-level traps are taken below M, or in M with MIE set; delegated ones
    // only in U, or in S with SIE set
    assign w_m_on     = (priv_lvl_i != PRIV_LVL_M) || mstatus_mie_i;
    assign w_s_on     = (priv_lvl_i == PRIV_LVL_U) ||
                        ((priv_lvl_i == PRIV_LVL_S) && mstatus_sie_i);
    assign w_deleg    = mideleg_i[c_IRQ_W-1:0] & ~c_MIDELEG_FORCED_ZERO;
    assign w_pend_en  = w_mip & mie_i[c_IRQ_W-1:0];
    assign w_m_elig   = w_pend_en & ~w_deleg & {c_IRQ_W{w_m_on}};
    assign w_s_elig   = w_pend_en &  w_deleg & {c_IRQ_W{w_s_on}};
    assign w_elig_any = {2'b00, w_m_elig | w_s_elig};

    logic [6:0]                   w_m_ord;
    logic [6:0]                   w_s_ord;
    logic                         w_win_found;
    asynchronous_exception_code_t w_win_code;
    privilege_level_t             w_win_target;

    assign w_m_ord = {w_m_elig[c_IRQ_MEI], w_m_elig[c_IRQ_MSI], w_m_elig[c_IRQ_MTI],
                      w_m_elig[c_IRQ_SEI], w_m_elig[c_IRQ_SSI], w_m_elig[c_IRQ_STI],
                      w_m_elig[c_IRQ_LCOFI]};
    assign w_s_ord = {w_s_elig[c_IRQ_MEI], w_s_elig[c_IRQ_MSI], w_s_elig[c_IRQ_MTI],
                      w_s_elig[c_IRQ_SEI], w_s_elig[c_IRQ_SSI], w_s_elig[c_IRQ_STI],
                      w_s_elig[c_IRQ_LCOFI]};
    assign w_win_found  = (|w_m_ord) || (|w_s_ord);
    assign w_win_code   = (|w_m_ord) ? pick_irq(w_m_ord) : pick_irq(w_s_ord);
    assign w_win_target = (|w_m_ord) ? PRIV_LVL_M : PRIV_LVL_S;

    arb_state_t       r_state, w_state_next;
    logic             r_valid, w_valid_next;
    logic [3:0]       r_cnt, w_cnt_next;
    logic [3:0]       r_code, w_code_next;
    privilege_level_t r_target, w_target_next;
    logic             r_intr, w_intr_next;
    logic             w_issue;

    // Arbiter state and request registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= ARB_IDLE;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_code   <= '0;
            r_target <= PRIV_LVL_M;
            r_intr   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_valid  <= w_valid_next;
            r_cnt    <= w_cnt_next;
            r_code   <= w_code_next;
            r_target <= w_target_next;
            r_intr   <= w_intr_next;
        end
    end

    // Next-state logic; the last hold-off cycle also evaluates like IDLE so a
    // new request appears exactly HOLDOFF_CYCLES cycles after valid drops
    always_comb begin
        w_state_next  = r_state;
        w_valid_next  = r_valid;
        w_cnt_next    = r_cnt;
        w_code_next   = r_code;
        w_target_next = r_target;
        w_intr_next   = r_intr;
        w_issue       = 1'b0;
        case (r_state)
            ARB_IDLE: w_issue = w_win_found;
            ARB_REQ: begin
                if (irq_ready_i && r_valid) begin
                    w_state_next = ARB_HOLDOFF;
                    w_valid_next = 1'b0;
                    w_cnt_next   = 4'(HOLDOFF_CYCLES);
                end else if (!w_elig_any[r_code]) begin
                    w_state_next = ARB_IDLE;
                    w_valid_next = 1'b0;
                end
            end
            ARB_HOLDOFF: begin
                if (r_cnt > 4'd1) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_cnt_next   = '0;
                    w_state_next = ARB_IDLE;
                    w_issue      = w_win_found;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
        if (w_issue) begin
            w_state_next  = ARB_REQ;
            w_valid_next  = 1'b1;
            w_code_next   = w_win_code;
            w_target_next = w_win_target;
            w_intr_next   = 1'b1;
        end
    end

    mcause_t w_cause;
    assign w_cause.interrupt = r_intr;
    assign w_cause.code      = (c_MXLEN-1)'(r_code);

    assign irq_valid_o       = r_valid;
    assign irq_cause_o       = w_cause;
    assign irq_target_priv_o = r_target;

    logic w_unused_bits;
    assign w_unused_bits = ^{w_wdata_sw, mie_i[MXLEN-1:c_IRQ_W], mideleg_i[MXLEN-1:c_IRQ_W]};

endmodule
`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_arbiter
// Description : Self-checking bench for interrupt_arbiter. A cycle-level
//               reference model derived from the architectural rules is
//               compared with the DUT after every clock edge, under directed
//               scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_arbiter;

    localparam int c_SYNC = 2;
    localparam int c_HOLD = 2;
`ifdef INTERRUPT_ARBITER_SYNC_EN
    localparam int c_LINE_DLY = c_SYNC;
`else
    localparam int c_LINE_DLY = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        irq_meip_i, irq_mtip_i, irq_msip_i, irq_seip_i, irq_lcofip_i;
    logic        mip_we_i;
    logic [63:0] mip_wdata_i, mie_i, mideleg_i;
    logic        mstatus_mie_i, mstatus_sie_i;
    logic [1:0]  priv_lvl_i;
    logic        irq_valid_o;
    logic        irq_ready_i;
    logic [63:0] irq_cause_o;
    logic [1:0]  irq_target_priv_o;
    logic [63:0] mip_o;

    interrupt_arbiter #(.MXLEN(64), .SYNC_STAGES(c_SYNC), .HOLDOFF_CYCLES(c_HOLD)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .irq_meip_i(irq_meip_i), .irq_mtip_i(irq_mtip_i),
        .irq_msip_i(irq_msip_i), .irq_seip_i(irq_seip_i),
        .irq_lcofip_i(irq_lcofip_i),
        .mip_we_i(mip_we_i), .mip_wdata_i(mip_wdata_i),
        .mie_i(mie_i), .mideleg_i(mideleg_i),
        .mstatus_mie_i(mstatus_mie_i), .mstatus_sie_i(mstatus_sie_i),
        .priv_lvl_i(priv_lvl_i),
        .irq_valid_o(irq_valid_o), .irq_ready_i(irq_ready_i),
        .irq_cause_o(irq_cause_o), .irq_target_priv_o(irq_target_priv_o),
        .mip_o(mip_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_mip;
    bit          m_sw_seip;
    bit          m_req;
    bit          m_intr;
    int          m_code;
    logic [1:0]  m_tgt;
    int          m_edge;
    int          m_hs_edge;
    logic [3:0]  m_pipe [0:8];
    int          prio [7] = '{11, 3, 7, 9, 1, 5, 13};

    function automatic bit mdl_elig(input int code, input bit want_m);
        bit pend;
        bit deleg;
        pend  = m_mip[code] & mie_i[code];
        deleg = mideleg_i[code] && !(code == 3 || code == 7 || code == 11);
        if (!deleg)
            return want_m && pend && (priv_lvl_i != 2'd3 || mstatus_mie_i);
        return !want_m && pend && (priv_lvl_i == 2'd0 || (priv_lvl_i == 2'd1 && mstatus_sie_i));
    endfunction

    task automatic mdl_reset();
        m_mip = '0; m_sw_seip = 0; m_req = 0; m_intr = 0; m_code = 0; m_tgt = 2'd3;
        m_edge = 0; m_hs_edge = -1000;
        for (int s = 0; s < 9; s++) m_pipe[s] = '0;
    endtask

    task automatic mdl_step();
        bit         found;
        bit         win_m;
        int         win_code;
        logic [3:0] ln;
        bit         lcof;
        m_edge++;
        found = 0; win_m = 1; win_code = 0;
        for (int lvl = 0; lvl < 2; lvl++)
            for (int k = 0; k < 7; k++)
                if (!found && mdl_elig(prio[k], lvl == 0)) begin
                    found = 1; win_code = prio[k]; win_m = (lvl == 0);
                end
        if (m_req) begin
            if (irq_ready_i) begin
                m_req = 0; m_hs_edge = m_edge;
            end else if (!(mdl_elig(m_code, 1) || mdl_elig(m_code, 0))) begin
                m_req = 0;
            end
        end else if (found && m_edge >= m_hs_edge + c_HOLD) begin
            m_req = 1; m_intr = 1; m_code = win_code; m_tgt = win_m ? 2'd3 : 2'd1;
        end
        for (int s = 8; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = {irq_seip_i, irq_msip_i, irq_mtip_i, irq_meip_i};
        ln = m_pipe[c_LINE_DLY];
        lcof = m_mip[13];
        if (irq_lcofip_i) lcof = 1;
        else if (mip_we_i && !mip_wdata_i[13]) lcof = 0;
        if (mip_we_i) begin
            m_mip[1] = mip_wdata_i[1];
            m_mip[5] = mip_wdata_i[5];
            m_sw_seip = mip_wdata_i[9];
        end
        m_mip[13] = lcof;
        m_mip[11] = ln[0];
        m_mip[7]  = ln[1];
        m_mip[3]  = ln[2];
        m_mip[9]  = m_sw_seip | ln[3];
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rstn_i) mdl_step();
        #1;
        check_eq("valid", {63'd0, irq_valid_o}, {63'd0, m_req});
        check_eq("cause", irq_cause_o, m_intr ? (64'h8000_0000_0000_0000 | 64'(m_code)) : 64'd0);
        check_eq("target", {62'd0, irq_target_priv_o}, {62'd0, m_tgt});
        check_eq("mip", mip_o, m_mip);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !irq_valid_o; i++) tick();
        check_eq(tag, {63'd0, irq_valid_o}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn_i = 0; irq_meip_i = 0; irq_mtip_i = 0; irq_msip_i = 0; irq_seip_i = 0;
        irq_lcofip_i = 0; mip_we_i = 0; mip_wdata_i = '0; mie_i = '0; mideleg_i = '0;
        mstatus_mie_i = 0; mstatus_sie_i = 0; priv_lvl_i = 2'd3; irq_ready_i = 0;
        mdl_reset();
        tick(); tick();
        check_eq("rst_target", {62'd0, irq_target_priv_o}, 64'd3);
        @(negedge clk_i) rstn_i = 1;
        tick();

        // MSI beats MTI in M mode; after hand-off MTI follows
        mstatus_mie_i = 1; mie_i = 64'h888; irq_mtip_i = 1; irq_msip_i = 1;
        wait_valid("d1_valid", 10);
        check_eq("d1_cause_msi", irq_cause_o, 64'h8000_0000_0000_0003);
        check_eq("d1_target", {62'd0, irq_target_priv_o}, 64'd3);
        irq_ready_i = 1; irq_msip_i = 0;
        tick();
        irq_ready_i = 0;
        tick();
        check_eq("d1_holdoff", {63'd0, irq_valid_o}, 64'd0);
        tick();
        check_eq("d1_cause_mti", irq_cause_o, 64'h8000_0000_0000_0007);
        irq_mtip_i = 0;
        tick(); tick();

        // Delegated STI from U mode; suppressed in M mode
        priv_lvl_i = 2'd0; mideleg_i = 64'h222; mie_i = 64'h222; mstatus_mie_i = 0;
        mip_we_i = 1; mip_wdata_i = 64'h20;
        tick();
        mip_we_i = 0;
        wait_valid("d2_valid", 5);
        check_eq("d2_cause_sti", irq_cause_o, 64'h8000_0000_0000_0005);
        check_eq("d2_target_s", {62'd0, irq_target_priv_o}, 64'd1);
        priv_lvl_i = 2'd3;
        tick();
        check_eq("d2_m_mode_drop", {63'd0, irq_valid_o}, 64'd0);
        tick(); tick();
        check_eq("d2_m_mode_quiet", {63'd0, irq_valid_o}, 64'd0);
        mip_we_i = 1; mip_wdata_i = 64'h0;
        tick();
        mip_we_i = 0; mideleg_i = '0;

        // Withdrawal: MEI pending, then mie bit 11 cleared before ready
        mstatus_mie_i = 1; mie_i = 64'h800; irq_meip_i = 1;
        wait_valid("d3_valid", 10);
        check_eq("d3_cause_mei", irq_cause_o, 64'h8000_0000_0000_000B);
        mie_i = 64'h0;
        tick();
        check_eq("d3_withdrawn", {63'd0, irq_valid_o}, 64'd0);
        tick();

        // Hold-off: valid low for exactly HOLDOFF_CYCLES with MEIP held
        mie_i = 64'h800;
        wait_valid("d4_valid", 10);
        irq_ready_i = 1;
        tick();
        irq_ready_i = 0;
        check_eq("d4_low0", {63'd0, irq_valid_o}, 64'd0);
        tick();
        check_eq("d4_low1", {63'd0, irq_valid_o}, 64'd0);
        tick();
        check_eq("d4_reissue", {63'd0, irq_valid_o}, 64'd1);
        check_eq("d4_cause", irq_cause_o, 64'h8000_0000_0000_000B);

        // LCOF pulse wins over a same-cycle clearing write
        mie_i = 64'h0;
        irq_lcofip_i = 1; mip_we_i = 1; mip_wdata_i = 64'h0;
        tick();
        irq_lcofip_i = 0;
        check_eq("d5_lcof_set", {63'd0, mip_o[13]}, 64'd1);
        tick();
        check_eq("d5_lcof_clr", {63'd0, mip_o[13]}, 64'd0);
        mip_we_i = 0;

        // Asynchronous reset in the middle of a request
        mie_i = 64'h800;
        wait_valid("d6_valid", 10);
        #2 rstn_i = 0;
        #1;
        check_eq("d6_rst_valid", {63'd0, irq_valid_o}, 64'd0);
        check_eq("d6_rst_mip", mip_o, 64'd0);
        mdl_reset();
        @(negedge clk_i) rstn_i = 1;
        for (int i = 0; i < 1 + c_LINE_DLY; i++) tick();
        check_eq("d6_not_yet", {63'd0, irq_valid_o}, 64'd0);
        tick();
        check_eq("d6_reassert", {63'd0, irq_valid_o}, 64'd1);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) irq_meip_i = ~irq_meip_i;
            if ($urandom_range(0, 7) == 0) irq_mtip_i = ~irq_mtip_i;
            if ($urandom_range(0, 7) == 0) irq_msip_i = ~irq_msip_i;
            if ($urandom_range(0, 7) == 0) irq_seip_i = ~irq_seip_i;
            irq_lcofip_i = ($urandom_range(0, 19) == 0);
            mip_we_i     = ($urandom_range(0, 9) == 0);
            mip_wdata_i  = {$urandom, $urandom};
            irq_ready_i  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) mie_i = {$urandom, $urandom} | 64'(($urandom_range(0, 1)) ? 14'h2AAA : 14'h0);
            if ($urandom_range(0, 49) == 0) mideleg_i = {$urandom, $urandom};
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 2))
                    0:       priv_lvl_i = 2'd0;
                    1:       priv_lvl_i = 2'd1;
                    default: priv_lvl_i = 2'd3;
                endcase
            end
            if ($urandom_range(0, 19) == 0) begin
                mstatus_mie_i = 1'($urandom);
                mstatus_sie_i = 1'($urandom);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
